// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores over a req/ack data-memory port, stalls upstream while busy, loads MEM/WB.
// Optional macro MEM_ALIGN_CHECK_EN turns misaligned accesses into flagged bubbles instead of requests.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic [2:0]  Mem_i,
    input  logic        zero_i,
    input  logic [31:0] alu_ans_i,
    input  logic [31:0] rtdata_i,
    input  logic [4:0]  WBreg_i,
    input  logic [31:0] pc_add4_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i,
    output logic        stall_o,
    output logic        pcsrc_o,
    output logic [1:0]  WB_o,
    output logic [31:0] rdata_o,
    output logic [31:0] alu_ans_o,
    output logic [4:0]  WBreg_o,
    output logic [31:0] pc_add4_o,
    output logic        err_o,
    output logic        misalign_o,
    output logic [1:0]  state_o
);

    // Handshake: dm_req_o rises the cycle after an access is seen in IDLE and stays high, with
    // we/addr/wdata stable, until the cycle dm_ack_i pulses; an ack in any other cycle is ignored.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             mis_q, mis_d;
    logic [1:0]       wb_q, wb_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      alu_q, alu_d;
    logic [4:0]       wbreg_q, wbreg_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             stall;
    logic             access;
    logic             misaligned;

    always_comb begin
        access = Mem_i[1] | Mem_i[0];
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = access & (alu_ans_i[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mis_d   = 1'b0;
        stall   = 1'b0;
        // MEM/WB takes a bubble unless an instruction completes this cycle
        wb_d    = 2'b00;
        rdata_d = 32'h0;
        alu_d   = 32'h0;
        wbreg_d = 5'h0;
        pc4_d   = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    stall   = 1'b1;
                    state_d = S_REQ;
                    cnt_d   = '0;
                end else if (misaligned) begin
                    mis_d = 1'b1;
                end else begin
                    wb_d    = WB_i;
                    alu_d   = alu_ans_i;
                    wbreg_d = WBreg_i;
                    pc4_d   = pc_add4_i;
                end
            end
            S_REQ: begin
                if (dm_ack_i) begin
                    state_d = S_IDLE;
                    wb_d    = WB_i;
                    rdata_d = Mem_i[1] ? dm_rdata_i : 32'h0;
                    alu_d   = alu_ans_i;
                    wbreg_d = WBreg_i;
                    pc4_d   = pc_add4_i;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_ABORT: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            wb_q    <= 2'b00;
            rdata_q <= 32'h0;
            alu_q   <= 32'h0;
            wbreg_q <= 5'h0;
            pc4_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            wb_q    <= wb_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            wbreg_q <= wbreg_d;
            pc4_q   <= pc4_d;
        end
    end

    assign dm_req_o   = (state_q == S_REQ);
    assign dm_we_o    = Mem_i[0] & ~Mem_i[1];
    assign dm_addr_o  = {alu_ans_i[31:2], 2'b00};
    assign dm_wdata_o = rtdata_i;
    assign stall_o    = stall;
    assign pcsrc_o    = Mem_i[2] & zero_i;
    assign WB_o       = wb_q;
    assign rdata_o    = rdata_q;
    assign alu_ans_o  = alu_q;
    assign WBreg_o    = wbreg_q;
    assign pc_add4_o  = pc4_q;
    assign err_o      = err_q;
    assign misalign_o = mis_q;
    assign state_o    = state_q;

endmodule
